vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator. It produces hsync, vsync, a display-enable signal, and visible-area pixel coordinates for any mode.
- Includes a two-stage pixel pipeline so that colour data supplied for a requested coordinate arrives aligned with the sync and display-enable outputs.
- Runs on one clock with a pixel clock-enable, so it can be clocked directly or behind a dot-clock divider.
- Sits between the dot-clock generator and the pixel/colour source feeding the DAC or HDMI encoder.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CNT_W, 12, width of counters and coordinates
- COLOR_W, 8, bits per colour channel

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel tick enable; all state advances only when this is 1
- red_in/green_in/blue_in  in  COLOR_W each  colour for the current req_x/req_y
- req_de  out  1  stage-1 request: req_x/req_y lie in the visible area
- req_x  out  CNT_W  stage-1 visible column, 0..H_VISIBLE-1 (0 when not visible)
- req_y  out  CNT_W  stage-1 visible row, 0..V_VISIBLE-1 (0 when not visible)
- hsync  out  1  stage-2 horizontal sync
- vsync  out  1  stage-2 vertical sync
- de  out  1  stage-2 display enable
- red/green/blue  out  COLOR_W each  stage-2 colour, forced to 0 when de=0
- line_start  out  1  one-clk pulse: stage 2 is at h=0
- frame_start  out  1  one-clk pulse: stage 2 is at h=0, v=0

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT; V_TOTAL likewise. Line order is sync, back porch, visible, front porch; the counters are 0 at the start of sync.
- Counters, on each tick (pix_ce=1):
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on an h wrap; at V_TOTAL-1 it wraps to 0.
  - No terminal-count overshoot: exactly H_TOTAL ticks per line and V_TOTAL lines per frame.
- Stage 1, registered from the current counters on each tick:
  - req_de = (h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1]) AND (v_cnt in the corresponding V range).
  - req_x = h_cnt-(H_SYNC+H_BACK) when h is visible, else 0. req_y is defined the same way using the V parameters.
  - Stage 1 also carries internal hsync_a = (h_cnt < H_SYNC) and vsync_a = (v_cnt < V_SYNC), plus h0/v0 flags.
- Stage 2, registered from stage 1 on each tick:
  - hsync = hsync_a XNOR HSYNC_POL; vsync is formed the same way with VSYNC_POL.
  - de = req_de.
  - Colour outputs = req_de ? *_in : 0, where *_in is sampled at the same edge.
- Latency: counters → stage 1 is one tick; stage 1 → stage 2 is one tick. The source must drive *_in combinationally (or within one tick) from req_x/req_y.
- line_start/frame_start: asserted for exactly one clk, on the tick edge where stage 2 loads h0 (and v0 for frame_start). They are low on every clk where pix_ce=0.
- pix_ce=0: all registers hold; hsync, vsync and de keep their values.
- Reset (async assert, any time including mid-frame):
  - counters 0; req_de, de, req_x, req_y, colours and pulses 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL (inactive).
  - After release, the first tick starts the frame at h=0, v=0.
- Elaboration: simulation $error if H_TOTAL or V_TOTAL ≥ 2^CNT_W, or if any timing parameter is 0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, *_in are ignored and stage 2 outputs 8 vertical colour bars, each H_VISIBLE/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
  - Bar index comes from a stage-1 bar counter that resets at req_x=0; no divider is used.
  - Timing and latency are identical to pass-through.
- Undefined: no test_mode port; colour is always pass-through.

Test Plan:
- Defaults, pix_ce=1, after reset:
  - hsync low for h=0..95 (96 clks), line period 800 clks.
  - vsync low for 2 lines (1600 clks), frame period 420000 clks.
  - frame_start period 420000 clks.
- Defaults, drive red_in=req_x[7:0]:
  - First de=1 is 2 clks after the counters reach h=144, v=35.
  - red=0 at the first de pixel and red=0x7F at the last (req_x=639).
  - de is high for 640 clks per line and for 480 lines.
- pix_ce toggling 1,0,1,0: line period is 1600 clks; line_start stays a single-clk pulse; outputs are stable during ce=0.
- HSYNC_POL=1, VSYNC_POL=1: sync outputs are inverted, and both sit at 0 during and immediately after reset.
- Reset asserted at h=400, v=200, held 3 clks:
  - All outputs go to their reset values asynchronously.
  - frame_start fires 2 ticks after release.
  - The next frame_start follows 420000 ticks later.
- VGA_TEST_PATTERN_EN with test_mode=1:
  - req_x 0..79 gives {FF,FF,FF}.
  - req_x 80..159 gives {FF,FF,00}.
  - req_x 560..639 gives {00,00,00}.
  - Blanking gives 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. Free-running h/v counters feed a
// two-stage pipeline: stage 1 publishes the pixel coordinate being requested
// from the colour source, and stage 2 registers that source's answer together
// with sync and display enable, so colour, sync and de leave aligned.
// All state advances only on pix_ce, so the block can run from a fast clock
// behind a dot-clock divider.
//
// Line order (and frame order) is sync, back porch, visible, front porch;
// the counters are 0 at the first sync pixel / sync line.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add a test_mode input that
// replaces the colour inputs with eight vertical colour bars.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pix_ce              pixel tick enable
//   test_mode           (VGA_TEST_PATTERN_EN only) select colour bars
//   red_in/green_in/
//   blue_in             colour for the current req_x/req_y
//   req_de, req_x,
//   req_y               stage-1 request (coordinate valid, column, row)
//   hsync, vsync, de    stage-2 sync and display enable
//   red/green/blue      stage-2 colour, zero outside the visible area
//   line_start          one-clk pulse when stage 2 loads h=0
//   frame_start         one-clk pulse when stage 2 loads h=0, v=0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12,
  parameter int COLOR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic               req_de,
  output logic [CNT_W-1:0]   req_x,
  output logic [CNT_W-1:0]   req_y,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LEN  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LEN  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_VISIBLE - 1);

  // Elaboration-time sanity checks on the mode parameters.
  if (H_TOTAL >= (2 ** CNT_W) || V_TOTAL >= (2 ** CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
  end
  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_zero
    $error("vga_timing_gen: timing parameters must be non-zero");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_vis, v_vis;
  logic             hsync_a, vsync_a, h0_s1, v0_s1;
  logic [COLOR_W-1:0] r_src, g_src, b_src;

  // Raster counters: h wraps after exactly H_TOTAL ticks, v steps on each h wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign h_vis = (h_cnt >= H_ACT_START) && (h_cnt <= H_ACT_END);
  assign v_vis = (v_cnt >= V_ACT_START) && (v_cnt <= V_ACT_END);

  // Stage 1: decode the counters into the coordinate request and raw sync flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_de  <= 1'b0;
      req_x   <= '0;
      req_y   <= '0;
      hsync_a <= 1'b0;
      vsync_a <= 1'b0;
      h0_s1   <= 1'b0;
      v0_s1   <= 1'b0;
    end else if (pix_ce) begin
      req_de  <= h_vis && v_vis;
      req_x   <= h_vis ? (h_cnt - H_ACT_START) : '0;
      req_y   <= v_vis ? (v_cnt - V_ACT_START) : '0;
      hsync_a <= (h_cnt < H_SYNC_LEN);
      vsync_a <= (v_cnt < V_SYNC_LEN);
      h0_s1   <= (h_cnt == '0);
      v0_s1   <= (v_cnt == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W_I = (H_VISIBLE / 8 > 0) ? (H_VISIBLE / 8) : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W_I - 1);

  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;

  // Bar tracker runs in step with req_x: restarts on the first visible pixel
  // and steps the bar index every BAR_W pixels, so no divider is needed.
  // The index saturates at the last bar when H_VISIBLE is not a multiple of 8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_ACT_START) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (h_vis) begin
        if (bar_px == BAR_LAST) begin
          bar_px <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + CNT_W'(1);
        end
      end
    end
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps onto
  // the index bits: red = ~idx[1], green = ~idx[2], blue = ~idx[0].
  always_comb begin
    r_src = red_in;
    g_src = green_in;
    b_src = blue_in;
    if (test_mode) begin
      r_src = {COLOR_W{~bar_idx[1]}};
      g_src = {COLOR_W{~bar_idx[2]}};
      b_src = {COLOR_W{~bar_idx[0]}};
    end
  end
`else
  assign r_src = red_in;
  assign g_src = green_in;
  assign b_src = blue_in;
`endif

  // Stage 2: polarity-corrected sync, display enable and blanked colour.
  // The start pulses are evaluated every clk so they drop on non-tick clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h0_s1;
      frame_start <= pix_ce && h0_s1 && v0_s1;
      if (pix_ce) begin
        hsync <= ~(hsync_a ^ HSYNC_POL);
        vsync <= ~(vsync_a ^ VSYNC_POL);
        de    <= req_de;
        red   <= req_de ? r_src : '0;
        green <= req_de ? g_src : '0;
        blue  <= req_de ? b_src : '0;
      end
    end
  end

endmodule
